// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS7 (x^7 + x^6 + 1) checker and the matching
// generator: checker state encoding, polynomial tap positions, generator seed
// and the feedback function.
// -----------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // Feedback taps of x^7 + x^6 + 1 (bit 0 holds the newest bit).
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    // Seed loaded by the matching generator.
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    function automatic logic prbs7_next(input logic [6:0] sr);
        return sr[PRBS7_TAP_HI] ^ sr[PRBS7_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// -----------------------------------------------------------------------------
// prbs7_lfsr
// 7-bit PRBS7 shift register. Shifts left when shift_en is high, taking either
// the received bit (sel_pred=0) or its own predicted bit (sel_pred=1), and
// presents the predicted next bit combinationally. Also used by the generator.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset (loads RST_VAL)
//   shift_en  advance the register this cycle
//   sel_pred  1: shift in predicted bit (free-run), 0: shift in din
//   din       received serial bit
//   sr        current register contents (bit 0 = newest bit)
//   expected  predicted next bit of the sequence
// -----------------------------------------------------------------------------
module prbs7_lfsr
    import prbs_pkg::*;
#(
    parameter logic [6:0] RST_VAL = 7'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       sel_pred,
    input  logic       din,
    output logic [6:0] sr,
    output logic       expected
);

    logic [6:0] sr_q;

    assign expected = prbs7_next(sr_q);
    assign sr       = sr_q;

    // NOTE: sequential state is only ever written with <= so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= RST_VAL;
        end else if (shift_en) begin
            sr_q <= {sr_q[5:0], (sel_pred ? expected : din)};
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// -----------------------------------------------------------------------------
// prbs7_checker
// Self-synchronising PRBS7 receiver. HUNT fills the local shift register with
// seven received bits, SYNC verifies LOCK_CNT further predicted bits, and
// LOCKED free-runs the local generator and counts mismatches as bit errors.
// LOSS_CNT consecutive errors in LOCKED drop back to HUNT.
//
// Optional: define PRBS7_CHECKER_BIT_CNT_EN to add bit_cnt, a saturating count
// of valid bits received in LOCKED (restarted on each lock) for BER estimates.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   din_valid  qualifies din for this cycle
//   din        received serial bit
//   clr_cnt    synchronous clear of err_cnt (and bit_cnt)
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per detected bit error
//   err_cnt    saturating error count
//   bit_cnt    (optional) saturating count of bits checked while locked
// -----------------------------------------------------------------------------
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS7_CHECKER_BIT_CNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    prbs_state_t      state_q, state_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
    logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

    logic       shift_en;
    logic       sel_pred;
    logic [6:0] sr;
    logic       expected;
    logic       mismatch;

    prbs7_lfsr #(
        .RST_VAL (7'h00)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .sel_pred (sel_pred),
        .din      (din),
        .sr       (sr),
        .expected (expected)
    );

    assign mismatch = (din != expected);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
        bit_cnt_d   = bit_cnt_q;
`endif
        shift_en    = din_valid;
        sel_pred    = (state_q == LOCKED);

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd6) begin
                        state_d = SYNC;
                        good_d  = 8'd0;
                    end
                end

                SYNC: begin
                    // An all-zero register would predict zeros forever, so it
                    // is treated as a failed sync just like a wrong bit.
                    if (mismatch || (sr == 7'h00)) begin
                        state_d = HUNT;
                        fill_d  = 3'd0;
                    end else begin
                        good_d = good_q + 8'd1;
                        if (good_q == LOCK_LAST) begin
                            state_d = LOCKED;
                            bad_d   = 4'd0;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
                            bit_cnt_d = 32'd0;
`endif
                        end
                    end
                end

                LOCKED: begin
`ifdef PRBS7_CHECKER_BIT_CNT_EN
                    if (bit_cnt_q != 32'hFFFF_FFFF) begin
                        bit_cnt_d = bit_cnt_q + 32'd1;
                    end
`endif
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (bad_q == LOSS_LAST) begin
                            state_d = HUNT;
                            fill_d  = 3'd0;
                            bad_d   = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else begin
                        bad_d = 4'd0;
                    end
                end

                default: begin
                    state_d = HUNT;
                    fill_d  = 3'd0;
                end
            endcase
        end

        // Clear beats a simultaneous error; the error pulse is still reported.
        if (clr_cnt) begin
            err_cnt_d = '0;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
            bit_cnt_d = 32'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            fill_q      <= 3'd0;
            good_q      <= 8'd0;
            bad_q       <= 4'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
            bit_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
    assign bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs7_checker
// Directed bench for prbs7_checker. A default instance (ERR_W=16) and a narrow
// instance (ERR_W=4) share all inputs. A hand-computed vector table covers
// reset, acquisition, a gap, one error and a clear; hand-written sequences
// cover single errors, loss/relock, all-zero input, gapped valid with clear,
// saturation and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din;
    logic        clr_cnt;
    logic        locked,    locked4;
    logic        err_pulse, err_pulse4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
`ifdef PRBS7_CHECKER_BIT_CNT_EN
    logic [31:0] bit_cnt, bit_cnt4;
`endif

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt;
    int locked_seen;
    logic [6:0] gen;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef PRBS7_CHECKER_BIT_CNT_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    prbs7_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_cnt   (err_cnt4)
`ifdef PRBS7_CHECKER_BIT_CNT_EN
        ,
        .bit_cnt   (bit_cnt4)
`endif
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic        d;
        logic        clr;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
        if (locked) locked_seen++;
    endtask

    // One cycle: with v=1 take the next stream bit (optionally inverted);
    // with v=0 drive garbage on din, which must be ignored.
    task automatic send(input logic v, input logic flip, input logic clr);
        logic b;
        din_valid = v;
        clr_cnt   = clr;
        if (v) begin
            b   = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            din = b ^ flip;
        end else begin
            din = ~din;
        end
        step();
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic restart();
        rst       = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        din       = 1'b0;
        step();
        step();
        check("reset_locked", locked, 0);
        check("reset_err_cnt", err_cnt, 0);
        rst       = 1'b1;
        gen       = 7'h7F;
        pulse_cnt = 0;
        locked_seen = 0;
    endtask

    // Clean stream from the seed: locked must rise exactly on valid bit 15.
    task automatic acquire(input logic gaps);
        for (int i = 1; i <= 15; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 14) check("acq_not_yet", locked, 0);
            if (i == 15) check("acq_locked", locked, 1);
            if (gaps) send(1'b0, 1'b0, 1'b0);
        end
        check("acq_err_cnt", err_cnt, 0);
    endtask

    task automatic add(input logic r, input logic v, input logic d, input logic c,
                       input logic el, input logic ep, input logic [15:0] ec);
        vec_t x;
        x.rst = r; x.v = v; x.d = d; x.clr = c;
        x.exp_locked = el; x.exp_pulse = ep; x.exp_cnt = ec;
        tbl.push_back(x);
    endtask

    initial begin
        rst = 1'b0; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        pulse_cnt = 0; locked_seen = 0; gen = 7'h7F;

        // Stream from seed 7F: bits 1..21 = 000000 1 00000 11 0000 1 0 1
        //     rst  v  d  clr  lock pulse cnt
        add(0, 0, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);   // bit 1
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);   // bit 6
        add(1, 1, 1, 0,   0, 0, 0);   // bit 7 -> SYNC
        add(1, 1, 0, 0,   0, 0, 0);   // bit 8
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 0);   // bit 10
        add(1, 0, 1, 0,   0, 0, 0);   // gap, garbage din
        add(1, 1, 0, 0,   0, 0, 0);   // bit 11
        add(1, 1, 0, 0,   0, 0, 0);
        add(1, 1, 1, 0,   0, 0, 0);
        add(1, 1, 1, 0,   0, 0, 0);   // bit 14
        add(1, 1, 0, 0,   1, 0, 0);   // bit 15 -> LOCKED
        add(1, 1, 0, 0,   1, 0, 0);   // bit 16
        add(1, 1, 1, 0,   1, 1, 1);   // bit 17 inverted
        add(1, 1, 0, 0,   1, 0, 1);   // bit 18
        add(1, 0, 0, 1,   1, 0, 0);   // clear during gap
        add(1, 1, 1, 0,   1, 0, 0);   // bit 19
        add(1, 1, 0, 0,   1, 0, 0);
        add(1, 1, 1, 0,   1, 0, 0);   // bit 21

        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            din_valid = tbl[i].v;
            din       = tbl[i].d;
            clr_cnt   = tbl[i].clr;
            step();
            check($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
            check($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].exp_pulse);
            check($sformatf("tbl%0d_cnt", i), err_cnt, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_cnt4", i), err_cnt4, tbl[i].exp_cnt[3:0]);
        end

        // Single error at bit 40, then 100 clean bits.
        restart();
        acquire(1'b0);
        for (int i = 16; i <= 39; i++) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        check("single_pulse", err_pulse, 1);
        check("single_cnt", err_cnt, 1);
        check("single_locked", locked, 1);
        send(1'b1, 1'b0, 1'b0);
        check("single_pulse_drop", err_pulse, 0);
        pulse_cnt = 0;
        for (int i = 0; i < 100; i++) send(1'b1, 1'b0, 1'b0);
        check("single_no_more_pulses", pulse_cnt, 0);
        check("single_cnt_hold", err_cnt, 1);
        check("single_still_locked", locked, 1);

        // Loss of lock on 4 consecutive errors, then relock 15 bits later.
        restart();
        acquire(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 1'b1, 1'b0);
            if (k < 4) check($sformatf("loss_hold%0d", k), locked, 1);
        end
        check("loss_unlocked", locked, 0);
        check("loss_cnt", err_cnt, 4);
        check("loss_pulse", err_pulse, 1);
        locked_seen = 0;
        for (int i = 0; i < 14; i++) send(1'b1, 1'b0, 1'b0);
        check("relock_not_early", locked_seen, 0);
        send(1'b1, 1'b0, 1'b0);
        check("relock", locked, 1);
        check("relock_cnt_held", err_cnt, 4);

        // All-zero input never locks.
        restart();
        for (int i = 0; i < 50; i++) begin
            din_valid = 1'b1;
            din       = 1'b0;
            step();
        end
        din_valid = 1'b0;
        check("zeros_never_locked", locked_seen, 0);
        check("zeros_err_cnt", err_cnt, 0);

        // Gapped valid, one error, then an error coinciding with clr_cnt.
        restart();
        acquire(1'b1);
        pulse_cnt = 0;
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        check("gap_err_pulse", err_pulse, 1);
        check("gap_err_cnt", err_cnt, 1);
        send(1'b0, 1'b0, 1'b0);
        check("gap_pulse_drop", err_pulse, 0);
        send(1'b1, 1'b0, 1'b0);
        check("gap_no_advance", err_cnt, 1);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_wins", err_cnt, 0);
        send(1'b0, 1'b0, 1'b0);
        check("clr_cnt_stays", err_cnt, 0);
        check("gap_pulse_total", pulse_cnt, 2);
        check("gap_locked", locked, 1);

        // 20 isolated errors: 16-bit counter reaches 20, 4-bit saturates at F.
        restart();
        acquire(1'b0);
        for (int k = 0; k < 20; k++) begin
            send(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) send(1'b1, 1'b0, 1'b0);
        end
        check("sat_cnt16", err_cnt, 20);
        check("sat_cnt4", err_cnt4, 4'hF);
        check("sat_locked", locked4, 1);

        // Reset mid-stream with an error on the same edge.
        rst       = 1'b0;
        din_valid = 1'b1;
        din       = ~(gen[6] ^ gen[5]);
        step();
        check("midrst_locked", locked, 0);
        check("midrst_cnt16", err_cnt, 0);
        check("midrst_cnt4", err_cnt4, 0);
        check("midrst_pulse", err_pulse, 0);
        rst       = 1'b1;
        din_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Serial pattern receiver and checker: the far end of the lab stimulus path.
- A PRBS7 bit stream (x^7 + x^6 + 1), driven through the DUT flip-flop chain, arrives one bit per qualified clock.
- The block self-synchronises to the stream, declares lock, then counts bit errors and drives a lock LED and error indicators on the MAX10 board.

Parameters:
- LOCK_CNT, 8: consecutive correct predicted bits in SYNC needed to declare lock (range 1..255).
- LOSS_CNT, 4: consecutive errors in LOCKED that force loss of lock (range 1..15).
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- din_valid  input  1  qualifies din for this cycle.
- din  input  1  received serial bit.
- clr_cnt  input  1  synchronous clear of err_cnt (and bit_cnt if present).
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected bit error.
- err_cnt  output  ERR_W  saturating error count.

Behaviour:
- Reset: interface is fixed as one clock (clk) with a synchronous, active-low reset (rst).
  - On a clk edge with rst=0: state=HUNT, sr=7'h00, fill/good/bad counters=0, locked=0, err_pulse=0, err_cnt=0.
- All outputs are registered. Cycles with din_valid=0 change nothing except err_pulse, which returns to 0.
- Prediction: expected = sr[6] ^ sr[5].
- HUNT:
  - Each valid bit: sr <= {sr[5:0], din}, fill++.
  - After the 7th valid bit, go to SYNC with good=0.
- SYNC:
  - Each valid bit: sr <= {sr[5:0], din}.
  - If din==expected and sr!=0: good++.
  - If good reaches LOCK_CNT: go to LOCKED, locked=1 on that same edge.
  - If din!=expected, or sr==7'h00 (all-zero lockup state): go to HUNT, fill=0.
  - No errors are counted outside LOCKED.
- LOCKED:
  - Each valid bit: sr <= {sr[5:0], expected}. The local generator free-runs, so errors do not propagate.
  - Match: bad=0.
  - Mismatch: err_pulse=1 on the next edge (a 1-cycle-latency pulse), err_cnt++ saturating at all ones, bad++.
  - When bad reaches LOSS_CNT: go to HUNT, locked=0 on that edge. The error that triggered loss is still counted.
- clr_cnt and an error on the same edge: clear wins, err_cnt=0, err_pulse still asserts.
- rst=0 mid-stream: immediate return to HUNT on that edge; all counters are lost.
- err_cnt holds its value across loss of lock. Only rst or clr_cnt clears it.

Optional Feature:
- Macro: PRBS7_CHECKER_BIT_CNT_EN.
- Defined:
  - Extra output port bit_cnt (32 bits), counting valid bits received while in LOCKED.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst=0 or clr_cnt. It also restarts from 0 on every entry into LOCKED.
  - Enables BER = err_cnt / bit_cnt.
- Undefined: the port and its logic are absent, and the other behaviour is identical.

Decomposition:
- Shared package (prbs_pkg):
  - state encoding HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2;
  - PRBS7 polynomial taps (6,5);
  - seed constant 7'h7F used by the matching generator.
- One natural sub-module, prbs7_lfsr: a 7-bit register with shift-in select (received vs predicted) and expected-bit output. It is reused by the future generator block.
- State machine and counters stay in prbs7_checker.

Test Plan:
- Lock acquisition: rst=0 for 2 cycles, then a clean PRBS7 from seed 7'h7F with din_valid=1 every cycle -> locked rises exactly at valid bit 7+LOCK_CNT=15, err_cnt=0.
- Single error: after lock, invert bit 40 -> err_pulse high for one cycle on the next edge, err_cnt=1, locked stays 1, and the following 100 bits add no further errors.
- Loss of lock: after lock, invert 4 consecutive bits -> err_cnt=4, locked falls on the 4th, state=HUNT, and the clean stream relocks 15 valid bits later.
- All-zero input: din=0 constant for 50 valid bits -> locked never asserts, err_cnt=0.
- Gapped valid plus clear: din_valid toggling 1/0 with one injected error, then clr_cnt asserted on the same edge as a second error -> err_cnt=0 afterwards, err_pulse seen for both errors, gaps do not advance the pattern.
- Saturation and reset: ERR_W=4 with 20 isolated errors -> err_cnt holds at 4'hF; rst=0 mid-stream -> locked=0 and err_cnt=0 on that edge.
